// File: rtl/gdm_pkg.sv
// Shared types and default constants for the gate delay meter and the
// generator configuration that drives it.
package gdm_pkg;

  localparam int unsigned GDM_CW      = 32;
  localparam int unsigned GDM_NCW     = 16;
  localparam logic [31:0] GDM_TIMEOUT = 32'd100000000;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_RISE,
    WAIT_FALL,
    DONE
  } gdm_state_e;

endpackage

// File: rtl/gate_delay_meter_if.sv
// Measurement bus: asynchronous trigger/pulse inputs and the result outputs.
// slave is the meter side, master the side that drives inputs and reads results.
interface gate_delay_meter_if
  import gdm_pkg::*;
#(
  parameter int unsigned CW  = GDM_CW,
  parameter int unsigned NCW = GDM_NCW
);
  logic           i_trigger;
  logic           i_pulse;
  logic [CW-1:0]  o_delay;
  logic [CW-1:0]  o_width;
  logic           o_valid;
  logic           o_timeout;
  logic [NCW-1:0] o_count;
  logic           busy;

  modport slave (
    input  i_trigger, i_pulse,
    output o_delay, o_width, o_valid, o_timeout, o_count, busy
  );

  modport master (
    output i_trigger, i_pulse,
    input  o_delay, o_width, o_valid, o_timeout, o_count, busy
  );
endinterface

// File: rtl/gate_delay_meter_sync_edge.sv
// Two-flop synchroniser followed by an edge register; produces one-cycle
// rise/fall strobes. Both inputs of the meter use this block so their
// latencies are identical and cancel in the delay/width differences.
module sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic i_async,
  output logic o_rise,
  output logic o_fall
);
  logic r_meta;
  logic r_sync;
  logic r_prev;

  // Synchroniser chain plus previous-level register for edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
      r_prev <= 1'b0;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign o_rise = r_sync & ~r_prev;
  assign o_fall = ~r_sync & r_prev;
endmodule

// File: rtl/gate_delay_meter.sv
// Gate delay meter: measures trigger-rise to pulse-rise delay and pulse
// width in clk cycles, reporting both with a one-cycle valid strobe or
// aborting with a timeout strobe if an awaited edge never arrives.
module gate_delay_meter
  import gdm_pkg::*;
#(
  parameter int unsigned    CW      = GDM_CW,
  parameter logic [CW-1:0]  TIMEOUT = CW'(GDM_TIMEOUT),
  parameter int unsigned    NCW     = GDM_NCW
) (
  input  logic               clk,
  input  logic               rst,
  gate_delay_meter_if.slave  bus
);
  logic w_trig_rise;
  logic w_unused_trig_fall;
  logic w_pulse_rise;
  logic w_pulse_fall;

  sync_edge u_sync_trig (
    .clk     (clk),
    .rst     (rst),
    .i_async (bus.i_trigger),
    .o_rise  (w_trig_rise),
    .o_fall  (w_unused_trig_fall)
  );

  sync_edge u_sync_pulse (
    .clk     (clk),
    .rst     (rst),
    .i_async (bus.i_pulse),
    .o_rise  (w_pulse_rise),
    .o_fall  (w_pulse_fall)
  );

  gdm_state_e     r_state;
  gdm_state_e     w_state_next;
  logic [CW-1:0]  r_elapsed;
  logic [CW-1:0]  r_delay;
  logic [CW-1:0]  r_width;
  logic [CW-1:0]  r_delay_out;
  logic [CW-1:0]  r_width_out;
  logic           r_valid;
  logic           r_timeout;
  logic [NCW-1:0] r_count;

  logic w_start;
  logic w_zero_delay;
  logic w_latch_delay;
  logic w_latch_width;
  logic w_timeout_hit;
  logic w_done;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  // Next-state and datapath control; events are checked before the
  // timeout so an edge at exactly elapsed==TIMEOUT is still measured
  always_comb begin
    w_state_next  = r_state;
    w_start       = 1'b0;
    w_zero_delay  = 1'b0;
    w_latch_delay = 1'b0;
    w_latch_width = 1'b0;
    w_timeout_hit = 1'b0;
    w_done        = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_trig_rise) begin
          w_start = 1'b1;
          if (w_pulse_rise) begin
            w_zero_delay = 1'b1;
            w_state_next = WAIT_FALL;
          end else begin
            w_state_next = WAIT_RISE;
          end
        end
      end
      WAIT_RISE: begin
        if (w_pulse_rise) begin
          w_latch_delay = 1'b1;
          w_state_next  = WAIT_FALL;
        end else if (r_elapsed == TIMEOUT) begin
          w_timeout_hit = 1'b1;
          w_state_next  = IDLE;
        end
      end
      WAIT_FALL: begin
        if (w_pulse_fall) begin
          w_latch_width = 1'b1;
          w_state_next  = DONE;
        end else if (r_elapsed == TIMEOUT) begin
          w_timeout_hit = 1'b1;
          w_state_next  = IDLE;
        end
      end
      DONE: begin
        w_done       = 1'b1;
        w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Elapsed counter (1 in the cycle after a reference edge) and internal
  // delay/width captures
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_elapsed <= '0;
      r_delay   <= '0;
      r_width   <= '0;
    end else begin
      if (w_start || w_latch_delay)
        r_elapsed <= CW'(1);
      else if (r_state == WAIT_RISE || r_state == WAIT_FALL)
        r_elapsed <= r_elapsed + CW'(1);
      if (w_zero_delay)
        r_delay <= '0;
      else if (w_latch_delay)
        r_delay <= r_elapsed;
      if (w_latch_width)
        r_width <= r_elapsed;
    end
  end

  // Registered results and strobes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_delay_out <= '0;
      r_width_out <= '0;
      r_valid     <= 1'b0;
      r_timeout   <= 1'b0;
      r_count     <= '0;
    end else begin
      r_valid   <= w_done;
      r_timeout <= w_timeout_hit;
      if (w_done) begin
        r_delay_out <= r_delay;
        r_width_out <= r_width;
        r_count     <= r_count + NCW'(1);
      end
    end
  end

  assign bus.o_delay   = r_delay_out;
  assign bus.o_width   = r_width_out;
  assign bus.o_valid   = r_valid;
  assign bus.o_timeout = r_timeout;
  assign bus.o_count   = r_count;
  assign bus.busy      = (r_state != IDLE);
endmodule

// File: tb/tb_gate_delay_meter.sv
// Directed bench for gate_delay_meter with TIMEOUT=50. Inputs change 2 ns
// after a rising edge; a monitor on the falling edge logs every strobe with
// a cycle stamp. An input driven just after edge k gives its strobe in the
// cycle after edge k+2, so a result of delay d, width w appears as o_valid
// on the (d+w+5)th falling edge after the trigger was driven, and a timeout
// from WAIT_RISE on the 54th.
module tb_gate_delay_meter;
  logic clk = 1'b0;
  logic rst = 1'b1;

  gate_delay_meter_if #(.CW(32), .NCW(16)) bus ();

  gate_delay_meter #(.CW(32), .TIMEOUT(32'd50), .NCW(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic        is_to;
    logic [31:0] d;
    logic [31:0] w;
    logic [15:0] cnt;
  } ev_t;

  typedef struct {
    int d;
    int w;
    int exp_d;
    int exp_w;
    int exp_lat;
  } vec_t;

  ev_t q[$];
  int  cyc = 0;
  int  n_chk = 0;
  int  n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // Log every strobe with its cycle stamp
  always @(negedge clk) begin
    if (rst) begin
      cyc = 0;
    end else begin
      ev_t e;
      cyc++;
      if (bus.o_valid || bus.o_timeout) begin
        check("valid_timeout_exclusive", {63'b0, bus.o_valid & bus.o_timeout}, 64'd0);
        e.cyc   = cyc;
        e.is_to = bus.o_timeout;
        e.d     = bus.o_delay;
        e.w     = bus.o_width;
        e.cnt   = bus.o_count;
        q.push_back(e);
      end
    end
  end

  task automatic expect_valid(input string name, input int idx, input int stamp,
                              input int d, input int w, input int cnt);
    if (q.size() > idx) begin
      check({name, "_is_valid"}, {63'b0, q[idx].is_to}, 64'd0);
      check({name, "_cycle"},    q[idx].cyc, stamp);
      check({name, "_delay"},    q[idx].d,   d);
      check({name, "_width"},    q[idx].w,   w);
      check({name, "_count"},    q[idx].cnt, cnt);
    end
  endtask

  vec_t vecs[5];
  int   t0;
  int   exp_cnt;
  int   prev_d;
  int   prev_w;

  initial begin
    vecs[0] = '{d: 10, w: 20, exp_d: 10, exp_w: 20, exp_lat: 35};
    vecs[1] = '{d: 0,  w: 5,  exp_d: 0,  exp_w: 5,  exp_lat: 10};
    vecs[2] = '{d: 1,  w: 1,  exp_d: 1,  exp_w: 1,  exp_lat: 7};
    vecs[3] = '{d: 3,  w: 1,  exp_d: 3,  exp_w: 1,  exp_lat: 9};
    vecs[4] = '{d: 17, w: 9,  exp_d: 17, exp_w: 9,  exp_lat: 31};

    bus.i_trigger = 1'b0;
    bus.i_pulse   = 1'b0;
    rst = 1'b1;
    tick(3);
    check("rst_delay",   bus.o_delay,   0);
    check("rst_width",   bus.o_width,   0);
    check("rst_valid",   bus.o_valid,   0);
    check("rst_timeout", bus.o_timeout, 0);
    check("rst_count",   bus.o_count,   0);
    check("rst_busy",    bus.busy,      0);
    rst = 1'b0;
    tick(5);
    exp_cnt = 0;

    // Table-driven measurements
    for (int i = 0; i < 5; i++) begin
      q.delete();
      t0 = cyc;
      bus.i_trigger = 1'b1;
      if (vecs[i].d == 0) begin
        bus.i_pulse = 1'b1;
      end else begin
        tick(vecs[i].d);
        bus.i_pulse = 1'b1;
      end
      tick(vecs[i].w);
      bus.i_pulse   = 1'b0;
      bus.i_trigger = 1'b0;
      tick(15);
      exp_cnt++;
      check($sformatf("vec%0d_events", i), q.size(), 1);
      expect_valid($sformatf("vec%0d", i), 0, t0 + vecs[i].exp_lat,
                   vecs[i].exp_d, vecs[i].exp_w, exp_cnt);
      check($sformatf("vec%0d_busy_after", i), bus.busy, 0);
      prev_d = vecs[i].exp_d;
      prev_w = vecs[i].exp_w;
    end

    // Timeout: trigger only; outputs keep the previous result
    q.delete();
    t0 = cyc;
    bus.i_trigger = 1'b1;
    tick(70);
    check("to_events", q.size(), 1);
    if (q.size() > 0) begin
      check("to_is_timeout", q[0].is_to, 1);
      check("to_cycle",      q[0].cyc, t0 + 54);
    end
    check("to_delay_kept", bus.o_delay, prev_d);
    check("to_width_kept", bus.o_width, prev_w);
    check("to_count_kept", bus.o_count, exp_cnt);
    check("to_busy",       bus.busy,    0);
    bus.i_trigger = 1'b0;
    tick(5);

    // Pulse rises exactly at elapsed == TIMEOUT
    q.delete();
    t0 = cyc;
    bus.i_trigger = 1'b1;
    tick(50);
    bus.i_pulse = 1'b1;
    tick(3);
    bus.i_pulse   = 1'b0;
    bus.i_trigger = 1'b0;
    tick(15);
    exp_cnt++;
    check("edge_to_events", q.size(), 1);
    expect_valid("edge_to", 0, t0 + 58, 50, 3, exp_cnt);

    // Retrigger during WAIT_FALL is ignored
    q.delete();
    t0 = cyc;
    bus.i_trigger = 1'b1;
    tick(6);
    bus.i_pulse = 1'b1;
    tick(2);
    bus.i_trigger = 1'b0;
    tick(2);
    bus.i_trigger = 1'b1;
    tick(10);
    bus.i_pulse = 1'b0;
    tick(60);
    bus.i_trigger = 1'b0;
    tick(5);
    exp_cnt++;
    check("retrig_events", q.size(), 1);
    expect_valid("retrig", 0, t0 + 25, 6, 14, exp_cnt);

    // Trigger whose rise strobe lands in the o_valid cycle is accepted
    q.delete();
    t0 = cyc;
    bus.i_trigger = 1'b1;
    tick(5);
    bus.i_pulse = 1'b1;
    tick(2);
    bus.i_trigger = 1'b0;
    tick(5);
    bus.i_pulse = 1'b0;
    tick(2);
    bus.i_trigger = 1'b1;
    tick(4);
    bus.i_pulse = 1'b1;
    tick(3);
    bus.i_pulse = 1'b0;
    tick(20);
    bus.i_trigger = 1'b0;
    tick(5);
    check("b2b_events", q.size(), 2);
    exp_cnt++;
    expect_valid("b2b_first", 0, t0 + 17, 5, 7, exp_cnt);
    exp_cnt++;
    expect_valid("b2b_second", 1, t0 + 26, 4, 3, exp_cnt);

    // Pulse already high at trigger: its fall is ignored, next rise measured
    bus.i_pulse = 1'b1;
    tick(10);
    q.delete();
    t0 = cyc;
    bus.i_trigger = 1'b1;
    tick(2);
    bus.i_pulse = 1'b0;
    tick(6);
    bus.i_pulse = 1'b1;
    tick(4);
    bus.i_pulse   = 1'b0;
    bus.i_trigger = 1'b0;
    tick(15);
    exp_cnt++;
    check("prehigh_events", q.size(), 1);
    expect_valid("prehigh", 0, t0 + 17, 8, 4, exp_cnt);

    // Async reset mid-WAIT_FALL; inputs held high give one spurious event
    bus.i_trigger = 1'b1;
    tick(5);
    bus.i_pulse = 1'b1;
    tick(6);
    check("pre_rst_busy", bus.busy, 1);
    #1 rst = 1'b1;
    #1;
    check("mid_rst_delay", bus.o_delay, 0);
    check("mid_rst_width", bus.o_width, 0);
    check("mid_rst_count", bus.o_count, 0);
    check("mid_rst_busy",  bus.busy,    0);
    check("mid_rst_valid", bus.o_valid, 0);
    tick(2);
    q.delete();
    rst = 1'b0;
    tick(3);
    check("spurious_busy", bus.busy, 1);
    tick(3);
    bus.i_pulse = 1'b0;
    tick(15);
    bus.i_trigger = 1'b0;
    tick(5);
    check("spurious_events", q.size(), 1);
    expect_valid("spurious", 0, 11, 0, 6, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
